// File: rtl/i2s_pkg.sv
// Shared types for the I2S slave receiver: deserializer FSM states and slot channel.
package i2s_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    DELAY,
    SHIFT,
    DRAIN
  } rx_state_t;

  typedef enum logic {
    CH_LEFT,
    CH_RIGHT
  } channel_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop for edge detection.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic any_edge
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level    = sync;
  assign rise     = sync & ~hist;
  assign any_edge = sync ^ hist;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S / left-justified slave receiver: oversamples BCLK/LRCK/SDAT and emits stereo frames.
// Defining I2SRX_STATS_EN adds frame_cnt, overrun_cnt and short_cnt statistics outputs.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int I2S_DELAY = 1,
  parameter int LEFT_HIGH = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                lrck,
  input  logic                sdat,
  output logic [SAMPLE_W-1:0] frame_left,
  output logic [SAMPLE_W-1:0] frame_right,
  output logic                frame_valid,
  input  logic                frame_ready,
  output logic                overrun,
  output logic                short_slot
`ifdef I2SRX_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [7:0]          overrun_cnt,
  output logic [7:0]          short_cnt
`endif
);

  localparam int               CNT_W    = $clog2(SAMPLE_W) + 1;
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic             LEFT_LVL = (LEFT_HIGH != 0);

  logic bclk_rise;
  logic lrck_lvl;
  logic lrck_edge;
  logic sdat_lvl;
  logic bclk_lvl_unused;
  logic bclk_edge_unused;
  logic lrck_rise_unused;
  logic sdat_rise_unused;
  logic sdat_edge_unused;

  sync_edge u_sync_bclk (
    .clk      (clk),
    .reset    (reset),
    .d        (bclk),
    .level    (bclk_lvl_unused),
    .rise     (bclk_rise),
    .any_edge (bclk_edge_unused)
  );

  sync_edge u_sync_lrck (
    .clk      (clk),
    .reset    (reset),
    .d        (lrck),
    .level    (lrck_lvl),
    .rise     (lrck_rise_unused),
    .any_edge (lrck_edge)
  );

  sync_edge u_sync_sdat (
    .clk      (clk),
    .reset    (reset),
    .d        (sdat),
    .level    (sdat_lvl),
    .rise     (sdat_rise_unused),
    .any_edge (sdat_edge_unused)
  );

  rx_state_t           state;
  logic [CNT_W-1:0]    bitcnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] left_buf;
  logic                have_left;

  logic [CNT_W-1:0]    pad;
  logic [SAMPLE_W-1:0] slot_data;
  logic                slot_short;
  logic                slot_closes;
  channel_t            slot_ch;
  logic                frame_done;
  logic                accept;
  logic                overrun_hit;
  logic                short_hit;

  // shreg holds the full sample once in DRAIN and is zero in DELAY, so only a
  // slot cut short in SHIFT needs left-alignment.
  always_comb begin
    pad         = FULL - bitcnt;
    slot_short  = (state == SHIFT) && (bitcnt < FULL);
    slot_data   = slot_short ? (shreg << pad) : shreg;
    slot_closes = lrck_edge && (state != WAIT_SYNC);
    // The level before the edge is the complement of the current synchronized level.
    slot_ch     = (lrck_lvl != LEFT_LVL) ? CH_LEFT : CH_RIGHT;
    frame_done  = slot_closes && (slot_ch == CH_RIGHT) && have_left;
    accept      = frame_valid && frame_ready;
    overrun_hit = frame_done && frame_valid && !frame_ready;
    short_hit   = slot_closes && slot_short;
  end

  // Handshake: frame_valid/frame_left/frame_right hold until the cycle where
  // frame_valid && frame_ready; a completing frame always loads, and only
  // raises overrun when the held frame is not being accepted that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= WAIT_SYNC;
      bitcnt      <= '0;
      shreg       <= '0;
      left_buf    <= '0;
      have_left   <= 1'b0;
      frame_left  <= '0;
      frame_right <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      short_slot  <= 1'b0;
    end else begin
      overrun    <= 1'b0;
      short_slot <= short_hit;

      if (lrck_edge) begin
        if (slot_closes) begin
          if (slot_ch == CH_LEFT) begin
            left_buf  <= slot_data;
            have_left <= 1'b1;
          end else begin
            have_left <= 1'b0;
          end
        end
        // A BCLK rise in the same clk belongs to the new slot.
        if (bclk_rise && (I2S_DELAY == 0)) begin
          state  <= SHIFT;
          shreg  <= SAMPLE_W'(sdat_lvl);
          bitcnt <= ONE;
        end else if (bclk_rise || (I2S_DELAY == 0)) begin
          state  <= SHIFT;
          shreg  <= '0;
          bitcnt <= '0;
        end else begin
          state  <= DELAY;
          shreg  <= '0;
          bitcnt <= '0;
        end
      end else if (bclk_rise) begin
        case (state)
          WAIT_SYNC: state <= WAIT_SYNC;
          DELAY:     state <= SHIFT;
          SHIFT: begin
            shreg  <= {shreg[SAMPLE_W-2:0], sdat_lvl};
            bitcnt <= bitcnt + ONE;
            if (bitcnt + ONE == FULL) state <= DRAIN;
          end
          DRAIN:     bitcnt <= FULL;
          default:   state <= WAIT_SYNC;
        endcase
      end

      if (frame_done) begin
        frame_left  <= left_buf;
        frame_right <= slot_data;
        frame_valid <= 1'b1;
        overrun     <= overrun_hit;
      end else if (accept) begin
        frame_valid <= 1'b0;
      end
    end
  end

`ifdef I2SRX_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_cnt   <= '0;
      overrun_cnt <= '0;
      short_cnt   <= '0;
    end else begin
      if (frame_done)  frame_cnt   <= frame_cnt + 16'd1;
      if (overrun_hit) overrun_cnt <= overrun_cnt + 8'd1;
      if (short_hit)   short_cnt   <= short_cnt + 8'd1;
    end
  end
`endif

endmodule
